// File: rtl/regfile_pkg.sv
// Shared defaults and types for the integer register file and its scoreboard.
// Pure declarations; no logic, no latency, no flow control.
package regfile_pkg;
   localparam int DEF_XLEN  = 32;
   localparam int DEF_NREGS = 32;
   localparam int DEF_AW    = $clog2(DEF_NREGS);

   typedef logic [DEF_AW-1:0]   reg_addr_t;
   typedef logic [DEF_XLEN-1:0] reg_data_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy tracking with popcount and WAW-violation flag.
// Lookups combinational, busy/count/err registered one cycle; no backpressure.
module rf_scoreboard
   import regfile_pkg::*;
#(
   parameter int NREGS = DEF_NREGS,
   parameter int NRD   = 2,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              issue_en,
   input  logic [AW-1:0]     issue_addr,
   input  logic              wb_en,
   input  logic [AW-1:0]     wb_addr,
   input  logic              flush,
   input  logic [NRD*AW-1:0] lk_addr,
   output logic [NRD-1:0]    lk_busy,
   output logic [AW:0]       busy_cnt,
   output logic              issue_err
);
   logic [NREGS-1:0] busy_q, busy_d;
   logic [AW:0]      busy_cnt_q, busy_cnt_d;
   logic             issue_err_q, issue_err_d;
   logic             wb_live, issue_live;

   assign wb_live    = wb_en && (wb_addr != '0);
   assign issue_live = issue_en && (issue_addr != '0);

   always_comb begin
      busy_d = busy_q;
      if (flush) begin
         busy_d = '0;
      end else begin
         // Issue applied after writeback so a same-cycle pair leaves the new producer pending.
         if (wb_live)    busy_d[wb_addr]    = 1'b0;
         if (issue_live) busy_d[issue_addr] = 1'b1;
      end
      busy_d[0] = 1'b0;

      issue_err_d = issue_live && !flush && busy_q[issue_addr]
                    && !(wb_en && (wb_addr == issue_addr));

      busy_cnt_d = '0;
      for (int r = 1; r < NREGS; r++)
         busy_cnt_d = busy_cnt_d + {{AW{1'b0}}, busy_d[r]};
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         busy_q      <= '0;
         busy_cnt_q  <= '0;
         issue_err_q <= 1'b0;
      end else begin
         busy_q      <= busy_d;
         busy_cnt_q  <= busy_cnt_d;
         issue_err_q <= issue_err_d;
      end
   end

   genvar g;
   for (g = 0; g < NRD; g++) begin : g_lk
      logic [AW-1:0] a;
      assign a          = lk_addr[g*AW +: AW];
      assign lk_busy[g] = busy_q[a] && !(wb_en && (wb_addr == a));
   end

   assign busy_cnt  = busy_cnt_q;
   assign issue_err = issue_err_q;
endmodule

// File: rtl/regfile_sb.sv
// Integer register file (r0 hardwired zero) with write forwarding and built-in scoreboard.
// Reads/forwarding zero latency, writes and busy state one edge; no backpressure.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int XLEN  = DEF_XLEN,
   parameter int NREGS = DEF_NREGS,
   parameter int NRD   = 2,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_en,
   input  logic [AW-1:0]       wr_addr,
   input  logic [XLEN-1:0]     wr_data,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic                issue_en,
   input  logic [AW-1:0]       issue_addr,
   input  logic                flush,
   output logic [AW:0]         busy_cnt,
   output logic                issue_err
);
   logic [XLEN-1:0] mem_q [NREGS-1:1];
   logic [XLEN-1:0] mem_d [NREGS-1:1];

   always_comb begin
      mem_d = mem_q;
      if (wr_en && (wr_addr != '0)) mem_d[wr_addr] = wr_data;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int r = 1; r < NREGS; r++) mem_q[r] <= '0;
      end else begin
         mem_q <= mem_d;
      end
   end

   genvar g;
   for (g = 0; g < NRD; g++) begin : g_rd
      logic [AW-1:0] a;
      assign a = rd_addr[g*AW +: AW];
      assign rd_data[g*XLEN +: XLEN] = (a == '0)                    ? '0      :
                                       (wr_en && (wr_addr == a))    ? wr_data :
                                                                      mem_q[a];
   end

   rf_scoreboard #(
      .NREGS (NREGS),
      .NRD   (NRD),
      .AW    (AW)
   ) u_sb (
      .clk        (clk),
      .rst        (rst),
      .issue_en   (issue_en),
      .issue_addr (issue_addr),
      .wb_en      (wr_en),
      .wb_addr    (wr_addr),
      .flush      (flush),
      .lk_addr    (rd_addr),
      .lk_busy    (rd_busy),
      .busy_cnt   (busy_cnt),
      .issue_err  (issue_err)
   );
endmodule
